// File: rtl/sccb_responder_pkg.sv
// Shared types and constants for the SCCB responder: FSM states, R/W bit
// encoding and bit counter width.
package sccb_responder_pkg;

    localparam int   BIT_CNT_W   = 4;
    localparam logic SCCB_WR_BIT = 1'b0;
    localparam logic SCCB_RD_BIT = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ACK_ID,
        ST_SUB,
        ST_ACK_SUB,
        ST_WR,
        ST_ACK_WR,
        ST_RD,
        ST_RD_ACK,
        ST_IGNORE
    } sccb_state_e;

endpackage

// File: rtl/sccb_responder_if.sv
// SCCB pad signals plus the synchronous register-access port of the responder.
interface sccb_responder_if;

    logic       sioc_in;
    logic       siod_in;
    logic       siod_oe;
    logic       reg_we;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave (
        input  sioc_in, siod_in, reg_rdata,
        output siod_oe, reg_we, reg_addr, reg_wdata, busy
    );

    modport master (
        output sioc_in, siod_in, reg_rdata,
        input  siod_oe, reg_we, reg_addr, reg_wdata, busy
    );

endinterface

// File: rtl/sccb_responder_bus_sync.sv
// Synchronizes SIOC/SIOD into clk and produces registered one-cycle pulses for
// SCL edges and START/STOP conditions, plus the synced SIOD level.
module sccb_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sioc_in,
    input  logic siod_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda
);

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_h, sda_h;
    logic                   scl_s, sda_s;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Chains reset to the idle-bus level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_h    <= 1'b1;
            sda_h    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
            sda      <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], sioc_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], siod_in};
            scl_h    <= scl_s;
            sda_h    <= sda_s;
            scl_rise <= scl_s & ~scl_h;
            scl_fall <= ~scl_s & scl_h;
            start    <= scl_s & scl_h & sda_h & ~sda_s;
            stop     <= scl_s & scl_h & ~sda_h & sda_s;
            sda      <= sda_s;
        end
    end

endmodule

// File: rtl/sccb_responder.sv
// SCCB target: decodes 3-phase writes and 2-phase reads to DEV_ID and drives
// the external register port; SIOD is driven open-drain through siod_oe.
module sccb_responder
    import sccb_responder_pkg::*;
#(
    parameter logic [6:0] DEV_ID      = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    sccb_responder_if.slave     bus
);

    logic scl_rise, scl_fall, start, stop, sda;

    sccb_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .sioc_in  (bus.sioc_in),
        .siod_in  (bus.siod_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda      (sda)
    );

    sccb_state_e          state, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [7:0]           shreg, shreg_d, ptr, ptr_d, wdata, wdata_d, rx_byte;
    logic                 oe, oe_d, we, we_d, nack, nack_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= 8'h00;
            ptr     <= 8'h00;
            wdata   <= 8'h00;
            oe      <= 1'b0;
            we      <= 1'b0;
            nack    <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            shreg   <= shreg_d;
            ptr     <= ptr_d;
            wdata   <= wdata_d;
            oe      <= oe_d;
            we      <= we_d;
            nack    <= nack_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        ptr_d     = ptr;
        wdata_d   = wdata;
        oe_d      = oe;
        we_d      = 1'b0;
        nack_d    = nack;
        rx_byte   = {shreg[6:0], sda};

        if (stop) begin
            state_d   = ST_IDLE;
            oe_d      = 1'b0;
            bit_cnt_d = '0;
        end else if (start) begin
            state_d   = ST_ID;
            oe_d      = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state)
                ST_ID, ST_SUB, ST_WR: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt + 1'b1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_d = '0;
                            if (state == ST_ID) begin
                                state_d = (rx_byte[7:1] == DEV_ID) ? ST_ACK_ID : ST_IGNORE;
                            end else if (state == ST_SUB) begin
                                ptr_d   = rx_byte;
                                state_d = ST_ACK_SUB;
                            end else begin
                                we_d    = 1'b1;
                                wdata_d = rx_byte;
                                state_d = ST_ACK_WR;
                            end
                        end
                    end
                end
                // First fall after the 8th bit drives ACK; the next fall releases it.
                ST_ACK_ID, ST_ACK_SUB, ST_ACK_WR: begin
                    if (scl_fall) begin
                        if (!oe) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            if (state == ST_ACK_ID) begin
                                if (shreg[0] == SCCB_WR_BIT) begin
                                    state_d = ST_SUB;
                                end else begin
                                    state_d = ST_RD;
                                    shreg_d = bus.reg_rdata;
                                    oe_d    = ~bus.reg_rdata[7];
                                end
                            end else if (state == ST_ACK_SUB) begin
                                state_d = ST_WR;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            shreg_d = {shreg[6:0], 1'b0};
                            oe_d    = ~shreg[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        nack_d    = sda;
                        bit_cnt_d = 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        bit_cnt_d = '0;
                        if (nack) begin
                            state_d = ST_IGNORE;
                        end else begin
                            state_d = ST_RD;
                            shreg_d = bus.reg_rdata;
                            oe_d    = ~bus.reg_rdata[7];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.siod_oe   = oe;
    assign bus.reg_we    = we;
    assign bus.reg_addr  = ptr;
    assign bus.reg_wdata = wdata;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench: bit-banged SCCB master on a wired-AND SIOD line against the
// responder, with a 256x8 registered RAM as the external regfile.
module tb_sccb_responder;

    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    logic [7:0] mem [256];

    int n_chk = 0;
    int n_err = 0;
    int we_cnt = 0;
    int oe_rises = 0;
    logic [7:0] we_addr = 8'h00;
    logic [7:0] we_data = 8'h00;
    logic oe_q = 1'b0;

    sccb_responder_if bus ();

    sccb_responder #(.DEV_ID(7'h21), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.sioc_in = scl;
    assign bus.siod_in = sda_m & ~bus.siod_oe;

    always @(posedge clk) begin
        bus.reg_rdata <= mem[bus.reg_addr];
        if (bus.reg_we) begin
            mem[bus.reg_addr] <= bus.reg_wdata;
            we_cnt++;
            we_addr = bus.reg_addr;
            we_data = bus.reg_wdata;
        end
        if (bus.siod_oe && !oe_q) oe_rises++;
        oe_q <= bus.siod_oe;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_cond();
        sda_m = 1'b1; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b, output logic rb);
        sda_m = b;    wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        rb    = bus.siod_in; wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(v[i], b);
        send_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, b);
            d = {d[6:0], b};
        end
        send_bit(master_ack, b);
    endtask

    initial begin
        logic a0, a1, a2, b;
        logic [7:0] d;
        int we0, oe0;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h0A] = 8'h76;
        mem[8'h1E] = 8'h01;

        wait_clk(5);
        chk("rst_oe",    {31'b0, bus.siod_oe}, 0);
        chk("rst_we",    {31'b0, bus.reg_we},  0);
        chk("rst_addr",  {24'b0, bus.reg_addr},  0);
        chk("rst_wdata", {24'b0, bus.reg_wdata}, 0);
        chk("rst_busy",  {31'b0, bus.busy},    0);
        rst_n = 1'b1;
        wait_clk(10);

        // Plain write 0x42 / 0x12 / 0x80
        we0 = we_cnt; oe0 = oe_rises;
        start_cond();
        chk("wr_busy", {31'b0, bus.busy}, 1);
        send_byte(8'h42, a0); send_byte(8'h12, a1); send_byte(8'h80, a2);
        stop_cond();
        chk("wr_acks", {29'b0, a0, a1, a2}, 0);
        chk("wr_oe_pulses", oe_rises - oe0, 3);
        chk("wr_we_cnt", we_cnt - we0, 1);
        chk("wr_addr", {24'b0, we_addr}, 32'h12);
        chk("wr_data", {24'b0, we_data}, 32'h80);
        chk("wr_wdata_held", {24'b0, bus.reg_wdata}, 32'h80);
        chk("wr_busy_end", {31'b0, bus.busy}, 0);

        // Pointer write, then read with NACK
        we0 = we_cnt;
        start_cond(); send_byte(8'h42, a0); send_byte(8'h0A, a1); stop_cond();
        start_cond(); send_byte(8'h43, a2); recv_byte(1'b1, d); stop_cond();
        chk("rd_acks", {29'b0, a0, a1, a2}, 0);
        chk("rd_data", {24'b0, d}, 32'h76);
        chk("rd_no_we", we_cnt - we0, 0);
        chk("rd_oe_idle", {31'b0, bus.siod_oe}, 0);

        // Read with master ACK repeats the same register
        start_cond(); send_byte(8'h43, a0);
        recv_byte(1'b0, d);
        chk("rd_rep1", {24'b0, d}, 32'h76);
        recv_byte(1'b1, d);
        chk("rd_rep2", {24'b0, d}, 32'h76);
        stop_cond();

        // Wrong ID is ignored, following write still works
        oe0 = oe_rises; we0 = we_cnt;
        start_cond(); send_byte(8'h60, a0); send_byte(8'h12, a1); stop_cond();
        chk("badid_nack", {31'b0, a0}, 1);
        chk("badid_no_oe", oe_rises - oe0, 0);
        chk("badid_no_we", we_cnt - we0, 0);
        start_cond(); send_byte(8'h42, a0); send_byte(8'h3A, a1); send_byte(8'h04, a2); stop_cond();
        chk("after_bad_acks", {29'b0, a0, a1, a2}, 0);
        chk("after_bad_we", we_cnt - we0, 1);
        chk("after_bad_addr", {24'b0, we_addr}, 32'h3A);
        chk("after_bad_data", {24'b0, we_data}, 32'h04);

        // Stop after 5 data bits aborts the byte
        we0 = we_cnt;
        start_cond(); send_byte(8'h42, a0); send_byte(8'h11, a1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, b);
        stop_cond();
        chk("abort_no_we", we_cnt - we0, 0);
        chk("abort_ptr", {24'b0, bus.reg_addr}, 32'h11);
        chk("abort_idle", {31'b0, bus.busy}, 0);

        // Repeated start switches to read of the just-set pointer
        start_cond(); send_byte(8'h42, a0); send_byte(8'h1E, a1);
        start_cond(); send_byte(8'h43, a2); recv_byte(1'b1, d); stop_cond();
        chk("rs_acks", {29'b0, a0, a1, a2}, 0);
        chk("rs_data", {24'b0, d}, 32'h01);

        // Reset asserted while ACK_SUB drives SIOD
        start_cond(); send_byte(8'h42, a0);
        for (int i = 7; i >= 0; i--) send_bit(((8'h5A >> i) & 1) != 0, b);
        sda_m = 1'b1; wait_clk(Q);
        chk("acksub_oe", {31'b0, bus.siod_oe}, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe",    {31'b0, bus.siod_oe}, 0);
        chk("rst_mid_busy",  {31'b0, bus.busy}, 0);
        chk("rst_mid_addr",  {24'b0, bus.reg_addr}, 0);
        chk("rst_mid_wdata", {24'b0, bus.reg_wdata}, 0);
        chk("rst_mid_we",    {31'b0, bus.reg_we}, 0);
        wait_clk(3); scl = 1'b1; wait_clk(3);
        rst_n = 1'b1;
        wait_clk(10);
        we0 = we_cnt;
        start_cond(); send_byte(8'h42, a0); send_byte(8'h55, a1); send_byte(8'h33, a2); stop_cond();
        chk("post_rst_acks", {29'b0, a0, a1, a2}, 0);
        chk("post_rst_we", we_cnt - we0, 1);
        chk("post_rst_addr", {24'b0, we_addr}, 32'h55);
        chk("post_rst_data", {24'b0, we_data}, 32'h33);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sccb_responder.md
# sccb_responder

SCCB (OV7670-style 3-wire, 2-wire mode) target that answers the camera-configuration master: it decodes 3-phase writes and 2-phase reads addressed to its device ID, and exposes the register accesses on a simple synchronous port. It sits opposite the SCCB initiator on the same SIOC/SIOD pair. It serves as the synthesizable camera stand-in for loopback testing of the configuration path and as the bus model in simulation.

## Interface
- DEV_ID, 7'h21, 7-bit device ID (write byte 0x42, read byte 0x43).
- SYNC_STAGES, 2, synchronizer depth on sioc_in/siod_in (≥2).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sioc_in  in  1  SIOC level sampled from the pad; asynchronous to clk.
- siod_in  in  1  SIOD level sampled from the pad; asynchronous to clk.
- siod_oe  out  1  1 = pull SIOD low (open-drain); pad logic forms `siod = siod_oe ? 0 : Z`.
- reg_we  out  1  one-cycle write strobe.
- reg_addr  out  8  current sub-address pointer; valid whenever reg_we=1 or a read byte is being loaded.
- reg_wdata  out  8  write data; valid with reg_we.
- reg_rdata  in  8  register value for reg_addr. Sampled 2 cycles after reg_addr settles, so a registered (ROM-style) regfile is legal.
- busy  out  1  1 from START detection to STOP detection.

## Operation
- Inputs pass through SYNC_STAGES flops plus one history flop. Edges are derived from the last two synced samples: scl_rise, scl_fall, start (SIOD 1→0 while SIOC=1), stop (SIOD 0→1 while SIOC=1).
- Bits are sampled on scl_rise, MSB first. Driven bits and ACK change only on scl_fall.
- States:
  - IDLE: waits for start. start → ID.
  - ID: after 8 bits, compare [7:1] with DEV_ID. Match → ACK_ID. Mismatch → IGNORE.
  - ACK_ID: siod_oe=1 for the 9th clock. Then bit0=0 → SUB; bit0=1 → RD.
  - SUB: 8 bits load the sub-address pointer. → ACK_SUB (siod_oe=1) → WR.
  - WR: 8 bits → reg_we pulse with reg_addr=pointer → ACK_WR (siod_oe=1) → IGNORE. Only one data byte per transaction; the pointer does not auto-increment.
  - RD: siod_oe = ~shift[7] for each bit, from a shift register loaded with reg_rdata at the ACK_ID release. After 8 bits → RD_ACK: SIOD released, master bit sampled. A master 1 (NACK) → IGNORE. A master 0 also reloads and repeats the same register.
  - IGNORE: siod_oe=0 until stop/start.
- stop in any state → IDLE, siod_oe=0 on the next cycle, busy=0.
- start in any state (repeated start) → ID, bit counter cleared, pointer kept.
- A start/stop detected mid-byte aborts that byte; no reg_we is issued for a partial byte.
- The pointer persists across transactions, so the standard SCCB read is write(ID,SUB)+stop, then read(ID).

## Timing
- Reset values: siod_oe=0, reg_we=0, reg_addr=0x00, reg_wdata=0x00, busy=0, state IDLE, pointer 0x00.
- Edge detection latency: SYNC_STAGES+1 clk cycles after the pad transition.
- siod_oe updates 1 cycle after the detected scl_fall.
- SIOC high and low phases must each be ≥ SYNC_STAGES+4 clk cycles. This is met by 100 kHz SCCB at 25 MHz clk.
- ACK release: siod_oe deasserts on the scl_fall that ends the 9th clock.
- reg_we asserts the cycle after the 8th scl_rise of WR, for exactly 1 cycle. reg_wdata is held until the next write.
- reg_rdata is captured at the scl_fall ending ACK_ID (or RD_ACK), ≥2 cycles after reg_addr was last changed.
- Simultaneous start and scl edge cannot occur (start requires SIOC=1 stable); if stop and start are both flagged, stop takes priority.
- rst_n asserted mid-transaction: immediate release of SIOD (siod_oe=0). After reset, the block waits for a fresh start.

## Structure
- Shared package: state enumeration, `SCCB_WR_BIT=0` / `SCCB_RD_BIT=1`, bit-count width (4).
- One sub-module, `sccb_bus_sync`: synchronizers plus scl_rise/scl_fall/start/stop pulse generation, parameterized by SYNC_STAGES. The FSM, shifter and pointer live in sccb_responder.
- Regfile is external. The test bench uses a 256×8 registered RAM.

## Test plan
- Write 0x42, 0x12, 0x80 then stop → three ACK low pulses, one reg_we with reg_addr=0x12, reg_wdata=0x80, busy falls after stop.
- Write 0x42, 0x0A then stop; read 0x43 with regfile[0x0A]=0x76 and master NACK → SIOD bits 0,1,1,1,0,1,1,0, no reg_we.
- Wrong ID 0x60 → siod_oe never asserts; the following valid write 0x42/0x3A/0x04 works.
- Stop after 5 bits of the data byte following 0x42, 0x11 → no reg_we, pointer=0x11, state IDLE.
- Repeated start after 0x42, 0x1E, then 0x43 with regfile[0x1E]=0x01 → returns 0x01.
- rst_n low during ACK_SUB → siod_oe=0 within the reset assertion, all outputs at reset values, next transaction succeeds.
